// File: rtl/mem_channel_arbiter_if.sv
// Bus bundle between NUM_CH requesting channels, the arbiter and the DDR issue stage.
// The arbiter sits on the slave modport; the environment drives the master modport.
interface mem_channel_arbiter_if #(
    parameter int NUM_CH       = 5,
    parameter int LEN_ADDR     = 32,
    parameter int LEN_MEM_DATA = 512,
    parameter int FIFO_DEPTH   = 16
);
    logic [NUM_CH*LEN_ADDR-1:0]     ch_in_addr;
    logic [NUM_CH*LEN_MEM_DATA-1:0] ch_in_data;
    logic [NUM_CH-1:0]              ch_in_wrt_enbl;
    logic [NUM_CH-1:0]              ch_in_avl;
    logic [NUM_CH-1:0]              ch_in_burst_done;
    logic [NUM_CH-1:0]              ch_out_ready_to_receive;
    logic [LEN_MEM_DATA-1:0]        ch_out_data;
    logic [NUM_CH-1:0]              ch_out_data_ready;

    logic                           mem_in_ready_to_receive;
    logic [LEN_MEM_DATA-1:0]        mem_in_data;
    logic                           mem_in_data_ready;
    logic [LEN_ADDR-1:0]            mem_out_addr;
    logic [LEN_MEM_DATA-1:0]        mem_out_data;
    logic                           out_wrt_enbl_mem;
    logic                           out_available_mem;
    logic                           out_burst_done;
    logic [$clog2(NUM_CH)-1:0]      out_ch_id;

    logic [$clog2(FIFO_DEPTH):0]    stat_occupancy;
    logic                           err_orphan_rd;

    modport slave (
        input  ch_in_addr, ch_in_data, ch_in_wrt_enbl, ch_in_avl, ch_in_burst_done,
        input  mem_in_ready_to_receive, mem_in_data, mem_in_data_ready,
        output ch_out_ready_to_receive, ch_out_data, ch_out_data_ready,
        output mem_out_addr, mem_out_data, out_wrt_enbl_mem, out_available_mem,
        output out_burst_done, out_ch_id, stat_occupancy, err_orphan_rd
    );

    modport master (
        output ch_in_addr, ch_in_data, ch_in_wrt_enbl, ch_in_avl, ch_in_burst_done,
        output mem_in_ready_to_receive, mem_in_data, mem_in_data_ready,
        input  ch_out_ready_to_receive, ch_out_data, ch_out_data_ready,
        input  mem_out_addr, mem_out_data, out_wrt_enbl_mem, out_available_mem,
        input  out_burst_done, out_ch_id, stat_occupancy, err_orphan_rd
    );
endinterface

// File: rtl/mem_channel_arbiter.sv
// N-channel memory arbiter: grants whole write bursts or single read address beats,
// keeps the issuing channel of every outstanding read in an in-order ID FIFO and
// steers each returning read beat back to that channel.
//
// state | meaning
// IDLE  | no grant held; arbitrate among eligible channels and register the winner
// GRANT | granted channel drives the memory side until its last beat transfers
//
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module mem_channel_arbiter #(
    parameter int NUM_CH        = 5,
    parameter int LEN_ADDR      = 32,
    parameter int LEN_MEM_DATA  = 512,
    parameter int RHS_BURST_LEN = 4,
    parameter int FIFO_DEPTH    = 16,
    parameter int ARB_MODE      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_channel_arbiter_if.slave  bus
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BEAT_W = (RHS_BURST_LEN > 1) ? $clog2(RHS_BURST_LEN) : 1;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CH_W-1:0]         r_grant;
    logic [CH_W-1:0]         r_rr_ptr;
    logic                    r_is_wr;
    logic [BEAT_W-1:0]       r_beat_cnt;

    logic [CH_W-1:0]         r_fifo [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
    logic [AW:0]             r_count;

    logic [BEAT_W-1:0]       r_ret_cnt;
    logic [LEN_MEM_DATA-1:0] r_rdata;
    logic [NUM_CH-1:0]       r_rdata_vld;
    logic                    r_err;

    logic [NUM_CH-1:0]       w_eligible;
    logic [CH_W-1:0]         w_winner;
    logic                    w_winner_vld;
    logic                    w_fifo_full, w_fifo_empty;
    logic                    w_xfer, w_last, w_push, w_pop, w_ret_vld;

    assign w_fifo_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);

    // Reads are only eligible while the ID FIFO (registered count) has room.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_eligible[i] = bus.ch_in_avl[i] & (bus.ch_in_wrt_enbl[i] | ~w_fifo_full);
    end

    // Winner select: loops run from the least to the most preferred candidate so the last hit wins.
    always_comb begin
        w_winner     = '0;
        w_winner_vld = 1'b0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (w_eligible[i]) begin
                    w_winner     = CH_W'(i);
                    w_winner_vld = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                if (w_eligible[(int'(r_rr_ptr) + k) % NUM_CH]) begin
                    w_winner     = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
                    w_winner_vld = 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and memory-side outputs; everything is zero outside GRANT.
    always_comb begin
        w_state_nxt                 = r_state;
        w_xfer                      = 1'b0;
        w_last                      = 1'b0;
        bus.mem_out_addr            = '0;
        bus.mem_out_data            = '0;
        bus.out_wrt_enbl_mem        = 1'b0;
        bus.out_available_mem       = 1'b0;
        bus.out_burst_done          = 1'b0;
        bus.out_ch_id               = '0;
        bus.ch_out_ready_to_receive = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_winner_vld) w_state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                w_xfer = bus.ch_in_avl[r_grant] & bus.mem_in_ready_to_receive;
                w_last = r_is_wr ? (bus.ch_in_burst_done[r_grant] |
                                    (r_beat_cnt == BEAT_W'(RHS_BURST_LEN - 1)))
                                 : 1'b1;
                bus.mem_out_addr      = bus.ch_in_addr[int'(r_grant)*LEN_ADDR +: LEN_ADDR];
                bus.mem_out_data      = bus.ch_in_data[int'(r_grant)*LEN_MEM_DATA +: LEN_MEM_DATA];
                bus.out_wrt_enbl_mem  = r_is_wr;
                bus.out_available_mem = bus.ch_in_avl[r_grant];
                bus.out_burst_done    = w_last;
                bus.out_ch_id         = r_grant;
                bus.ch_out_ready_to_receive[r_grant] = bus.mem_in_ready_to_receive;
                if (w_xfer && w_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant register, round-robin pointer and write beat counter; the access type is latched at grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_is_wr    <= 1'b0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= CH_W'(NUM_CH - 1);
        end else if (r_state == ST_IDLE && w_winner_vld) begin
            r_grant    <= w_winner;
            r_is_wr    <= bus.ch_in_wrt_enbl[w_winner];
            r_beat_cnt <= '0;
            r_rr_ptr   <= w_winner;
        end else if (w_xfer && r_is_wr) begin
            r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
        end
    end

    assign w_push    = w_xfer & ~r_is_wr;
    assign w_ret_vld = bus.mem_in_data_ready & ~w_fifo_empty;
    assign w_pop     = w_ret_vld & (r_ret_cnt == BEAT_W'(RHS_BURST_LEN - 1));

    // ID FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_grant;
    end

    // ID FIFO pointers and fill count; a simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Read return: register each beat and flag the FIFO-head channel; orphan beats only set the sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ret_cnt   <= '0;
            r_rdata     <= '0;
            r_rdata_vld <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rdata_vld <= '0;
            if (w_ret_vld) begin
                r_rdata                      <= bus.mem_in_data;
                r_rdata_vld[r_fifo[r_rd_ptr]] <= 1'b1;
                r_ret_cnt                    <= w_pop ? '0 : r_ret_cnt + 1'b1;
            end
            if (bus.mem_in_data_ready && w_fifo_empty) r_err <= 1'b1;
        end
    end

    assign bus.ch_out_data       = r_rdata;
    assign bus.ch_out_data_ready = r_rdata_vld;
    assign bus.stat_occupancy    = r_count;
    assign bus.err_orphan_rd     = r_err;
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: round-robin instance for most scenarios,
// fixed-priority instance for the starvation case.
module tb_mem_channel_arbiter;
    localparam int NCH = 5;
    localparam int LA  = 32;
    localparam int LD  = 512;

    logic clk;
    logic rst;

    logic [LA-1:0]  t_addr [NCH];
    logic [LD-1:0]  t_data [NCH];
    logic [NCH-1:0] t_wrt, t_avl, t_bdone;
    logic           t_rdy, t_rvalid;
    logic [LD-1:0]  t_rdata;
    logic [NCH-1:0] b_avl;

    int n_chk = 0;
    int n_err = 0;

    mem_channel_arbiter_if #(.NUM_CH(NCH), .LEN_ADDR(LA), .LEN_MEM_DATA(LD), .FIFO_DEPTH(16)) ifa ();
    mem_channel_arbiter_if #(.NUM_CH(NCH), .LEN_ADDR(LA), .LEN_MEM_DATA(LD), .FIFO_DEPTH(16)) ifb ();

    mem_channel_arbiter #(.NUM_CH(NCH), .LEN_ADDR(LA), .LEN_MEM_DATA(LD), .RHS_BURST_LEN(4),
                          .FIFO_DEPTH(16), .ARB_MODE(0)) u_dut_rr (.clk(clk), .rst(rst), .bus(ifa));
    mem_channel_arbiter #(.NUM_CH(NCH), .LEN_ADDR(LA), .LEN_MEM_DATA(LD), .RHS_BURST_LEN(4),
                          .FIFO_DEPTH(16), .ARB_MODE(1)) u_dut_fp (.clk(clk), .rst(rst), .bus(ifb));

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign ifa.ch_in_addr[g*LA +: LA] = t_addr[g];
        assign ifa.ch_in_data[g*LD +: LD] = t_data[g];
    end
    assign ifa.ch_in_wrt_enbl          = t_wrt;
    assign ifa.ch_in_avl               = t_avl;
    assign ifa.ch_in_burst_done        = t_bdone;
    assign ifa.mem_in_ready_to_receive = t_rdy;
    assign ifa.mem_in_data             = t_rdata;
    assign ifa.mem_in_data_ready       = t_rvalid;

    assign ifb.ch_in_addr              = '0;
    assign ifb.ch_in_data              = '0;
    assign ifb.ch_in_wrt_enbl          = '0;
    assign ifb.ch_in_avl               = b_avl;
    assign ifb.ch_in_burst_done        = '0;
    assign ifb.mem_in_ready_to_receive = 1'b1;
    assign ifb.mem_in_data             = '0;
    assign ifb.mem_in_data_ready       = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next accepted beat on the RR instance; capture what it presented.
    task automatic await_beat(output int ch, output logic [63:0] dat, output logic bd,
                              output logic [31:0] adr);
        logic got;
        got = 1'b0; ch = -1; dat = '0; bd = 1'b0; adr = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            if (ifa.out_available_mem && (ifa.ch_out_ready_to_receive != '0)) begin
                ch  = int'(ifa.out_ch_id);
                dat = ifa.mem_out_data[63:0];
                bd  = ifa.out_burst_done;
                adr = ifa.mem_out_addr;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk("beat_timeout", 64'(got), 64'd1);
    endtask

    // Four return beats; each must appear one cycle later on the expected channel.
    task automatic ret_burst(input int ch);
        logic [63:0] exp_d;
        for (int b = 0; b < 4; b++) begin
            exp_d    = 64'hD000 + 64'(ch * 16 + b);
            t_rvalid = 1'b1;
            t_rdata  = {448'd0, exp_d};
            cyc();
            chk("ret_vld", 64'(ifa.ch_out_data_ready), 64'd1 << ch);
            chk("ret_data", ifa.ch_out_data[63:0], exp_d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ch, ng;
        logic [63:0] dat;
        logic        bd, saw2;
        logic [31:0] adr;

        rst = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            t_addr[i] = 32'hA000_0000 + 32'(i * 16);
            t_data[i] = '0;
        end
        t_wrt = '0; t_avl = '0; t_bdone = '0;
        t_rdy = 1'b1; t_rvalid = 1'b0; t_rdata = '0; b_avl = '0;
        #3 rst = 1'b1;
        #2;
        chk("rst_ch_id",  64'(ifa.out_ch_id), 0);
        chk("rst_avail",  64'(ifa.out_available_mem), 0);
        chk("rst_occ",    64'(ifa.stat_occupancy), 0);
        chk("rst_err",    64'(ifa.err_orphan_rd), 0);
        chk("rst_dvld",   64'(ifa.ch_out_data_ready), 0);
        chk("rst_rdy",    64'(ifa.ch_out_ready_to_receive), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // fixed priority: channel 0 keeps winning, channel 2 starves
        b_avl = 5'b00101;
        ng = 0; saw2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ifb.out_available_mem) begin
                ng++;
                if (ifb.out_ch_id == 3'd2) saw2 = 1'b1;
            end
        end
        chk("fp_ch0_grants", 64'(ng), 6);
        chk("fp_ch2_starved", 64'(saw2), 0);
        b_avl = 5'b00100;
        ch = -1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (ifb.out_available_mem && ch < 0) ch = int'(ifb.out_ch_id);
        end
        chk("fp_ch2_after", 64'(ch), 2);
        b_avl = '0;

        // round robin reads 0,2,3 then 0 again
        t_avl = 5'b01101;
        await_beat(ch, dat, bd, adr);
        chk("rr_1st", 64'(ch), 0);
        chk("rr_addr0", 64'(adr), 64'hA000_0000);
        chk("rd_bdone", 64'(bd), 1);
        t_avl = 5'b01100;
        await_beat(ch, dat, bd, adr);
        chk("rr_2nd", 64'(ch), 2);
        chk("rr_addr2", 64'(adr), 64'hA000_0020);
        t_avl = 5'b01001;
        await_beat(ch, dat, bd, adr);
        chk("rr_3rd", 64'(ch), 3);
        chk("occ_3", 64'(ifa.stat_occupancy), 3);
        t_avl = 5'b00001;
        await_beat(ch, dat, bd, adr);
        chk("rr_4th", 64'(ch), 0);
        chk("occ_4", 64'(ifa.stat_occupancy), 4);
        t_avl = '0;
        ret_burst(0); ret_burst(2); ret_burst(3); ret_burst(0);
        t_rvalid = 1'b0;
        cyc();
        chk("ret_idle", 64'(ifa.ch_out_data_ready), 0);
        chk("occ_drained", 64'(ifa.stat_occupancy), 0);

        // reads from 3 then 1, return routing, orphan beat
        t_avl = 5'b01000;
        await_beat(ch, dat, bd, adr);
        chk("rd_ch3", 64'(ch), 3);
        t_avl = 5'b00010;
        await_beat(ch, dat, bd, adr);
        chk("rd_ch1", 64'(ch), 1);
        t_avl = '0;
        chk("pre_ret_vld", 64'(ifa.ch_out_data_ready), 0);
        chk("pre_err", 64'(ifa.err_orphan_rd), 0);
        ret_burst(3); ret_burst(1);
        t_rvalid = 1'b0;
        cyc();
        chk("ret_idle2", 64'(ifa.ch_out_data_ready), 0);
        t_rvalid = 1'b1;
        t_rdata  = {448'd0, 64'hDEAD};
        cyc();
        t_rvalid = 1'b0;
        chk("orphan_vld", 64'(ifa.ch_out_data_ready), 0);
        chk("orphan_err", 64'(ifa.err_orphan_rd), 1);
        cyc();
        chk("orphan_sticky", 64'(ifa.err_orphan_rd), 1);

        // channel 1 write burst of 4 with a stall on beat 2
        t_wrt = 5'b00010; t_avl = 5'b00010; t_bdone = '0;
        for (int b = 0; b < 4; b++) begin
            t_data[1] = {448'd0, 64'hBEEF_0000 + 64'(b)};
            if (b == 1) begin
                t_rdy = 1'b0;
                cyc();
                chk("wr_stall_rdy", 64'(ifa.ch_out_ready_to_receive), 0);
                chk("wr_stall_data", ifa.mem_out_data[63:0], 64'hBEEF_0001);
                chk("wr_stall_we", 64'(ifa.out_wrt_enbl_mem), 1);
                chk("wr_stall_bd", 64'(ifa.out_burst_done), 0);
                t_rdy = 1'b1;
            end
            await_beat(ch, dat, bd, adr);
            chk("wr4_ch", 64'(ch), 1);
            chk("wr4_data", dat, 64'hBEEF_0000 + 64'(b));
            chk("wr4_bdone", 64'(bd), (b == 3) ? 64'd1 : 64'd0);
        end
        chk("wr4_ended", 64'(ifa.out_available_mem), 0);
        // early end via ch_in_burst_done on beat 2
        for (int b = 0; b < 2; b++) begin
            t_data[1]  = {448'd0, 64'hCAFE_0000 + 64'(b)};
            t_bdone[1] = (b == 1);
            await_beat(ch, dat, bd, adr);
            chk("wr2_data", dat, 64'hCAFE_0000 + 64'(b));
            chk("wr2_bdone", 64'(bd), (b == 1) ? 64'd1 : 64'd0);
        end
        chk("wr2_ended", 64'(ifa.out_available_mem), 0);
        t_avl = '0; t_bdone = '0; t_wrt = '0;

        // full FIFO blocks reads but not writes
        t_avl = 5'b10000;
        for (int i = 0; i < 16; i++) begin
            await_beat(ch, dat, bd, adr);
            chk("fill_ch4", 64'(ch), 4);
        end
        chk("occ_full", 64'(ifa.stat_occupancy), 16);
        t_wrt = 5'b00010; t_avl = 5'b10010; t_bdone = 5'b00010;
        await_beat(ch, dat, bd, adr);
        chk("full_wr_a", 64'(ch), 1);
        await_beat(ch, dat, bd, adr);
        chk("full_wr_b", 64'(ch), 1);
        t_avl = 5'b10000; t_wrt = '0; t_bdone = '0;
        ng = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (ifa.out_available_mem) ng++;
        end
        chk("full_rd_blocked", 64'(ng), 0);
        ret_burst(4);
        t_rvalid = 1'b0;
        chk("occ_after_pop", 64'(ifa.stat_occupancy), 15);
        await_beat(ch, dat, bd, adr);
        chk("rd_after_pop", 64'(ch), 4);
        chk("occ_refull", 64'(ifa.stat_occupancy), 16);
        t_avl = '0;
        for (int i = 0; i < 16; i++) ret_burst(4);
        t_rvalid = 1'b0;
        cyc();
        chk("occ_wrap_empty", 64'(ifa.stat_occupancy), 0);

        // asynchronous reset during write beat 2
        t_wrt = 5'b00010; t_avl = 5'b00010; t_bdone = '0;
        t_data[1] = {448'd0, 64'h1111};
        await_beat(ch, dat, bd, adr);
        chk("pre_rst_ch", 64'(ch), 1);
        t_data[1] = {448'd0, 64'h2222};
        #1;
        chk("pre_rst_avail", 64'(ifa.out_available_mem), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_avail", 64'(ifa.out_available_mem), 0);
        chk("mid_rst_rdy", 64'(ifa.ch_out_ready_to_receive), 0);
        chk("mid_rst_data", ifa.mem_out_data[63:0], 0);
        chk("mid_rst_addr", 64'(ifa.mem_out_addr), 0);
        chk("mid_rst_we", 64'(ifa.out_wrt_enbl_mem), 0);
        chk("mid_rst_err", 64'(ifa.err_orphan_rd), 0);
        cyc(); cyc();
        rst = 1'b0;
        t_wrt = '0; t_avl = 5'b10001;
        await_beat(ch, dat, bd, adr);
        chk("post_rst_winner", 64'(ch), 0);
        t_avl = '0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
